mem_arbiter: RTL and testbench

Two-port arbiter in front of the byte-serial memory controller. It shares that controller between the instruction-fetch port (word reads only) and the data port (loads and stores of byte, half or word, signed or unsigned). It latches one request at a time and holds the controller inputs stable until the controller reports completion. It alternates grants when both ports wait, and can discard an in-flight fetch on a pipeline flush.

---
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/data request ports and memory-controller request bundle
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              i_valid;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ready;
  logic [31:0]       i_data;

  logic              d_valid;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [2:0]        d_len;
  logic [31:0]       d_wdata;
  logic              d_ready;
  logic [31:0]       d_rdata;

  logic              mc_valid;
  logic              mc_wr;
  logic [ADDR_W-1:0] mc_addr;
  logic [2:0]        mc_len;
  logic [31:0]       mc_data;
  logic              mc_ready;
  logic [31:0]       mc_res;

  // Arbiter side: accepts port requests, drives the controller request.
  modport slave (
    input  i_valid, i_addr, d_valid, d_wr, d_addr, d_len, d_wdata, mc_ready, mc_res,
    output i_ready, i_data, d_ready, d_rdata, mc_valid, mc_wr, mc_addr, mc_len, mc_data
  );

  // Environment side: requesters plus the memory controller.
  modport master (
    output i_valid, i_addr, d_valid, d_wr, d_addr, d_len, d_wdata, mc_ready, mc_res,
    input  i_ready, i_data, d_ready, d_rdata, mc_valid, mc_wr, mc_addr, mc_len, mc_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port fetch/data arbiter in front of the byte-serial memory controller
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  input  logic         flush,
  mem_arbiter_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e            state_q, state_d;
  logic              owner_is_d_q, owner_is_d_d;  // 0 = fetch port owns the controller
  logic              first_q, first_d;            // first BUSY cycle, controller result not yet meaningful
  logic              drop_q, drop_d;              // in-flight fetch was flushed, swallow its completion
  logic              last_d_q, last_d_d;          // previous grant went to the data port
  logic              mc_valid_q, mc_valid_d;
  logic              mc_wr_q, mc_wr_d;
  logic [ADDR_W-1:0] mc_addr_q, mc_addr_d;
  logic [2:0]        mc_len_q, mc_len_d;
  logic [31:0]       mc_data_q, mc_data_d;

  logic i_cand, grant_i, grant_d, complete;
  logic i_ready_c, d_ready_c;

  // Grant selection, request latching and completion pulses
  always_comb begin
    state_d      = state_q;
    owner_is_d_d = owner_is_d_q;
    first_d      = first_q;
    drop_d       = drop_q;
    last_d_d     = last_d_q;
    mc_valid_d   = mc_valid_q;
    mc_wr_d      = mc_wr_q;
    mc_addr_d    = mc_addr_q;
    mc_len_d     = mc_len_q;
    mc_data_d    = mc_data_q;
    i_ready_c    = 1'b0;
    d_ready_c    = 1'b0;

    // A flushed fetch is never granted; when both wait, the port not served last wins.
    i_cand   = bus.i_valid && !flush;
    grant_d  = bus.d_valid && !(i_cand && last_d_q);
    grant_i  = i_cand && !grant_d;
    complete = (state_q == BUSY) && !first_q && bus.mc_ready;

    if (rdy_in) begin
      case (state_q)
        IDLE: begin
          if (grant_i || grant_d) begin
            state_d      = BUSY;
            owner_is_d_d = grant_d;
            first_d      = 1'b1;
            drop_d       = 1'b0;
            last_d_d     = grant_d;
            mc_valid_d   = 1'b1;
            if (grant_d) begin
              mc_wr_d   = bus.d_wr;
              mc_addr_d = bus.d_addr;
              mc_len_d  = bus.d_len;
              mc_data_d = bus.d_wdata;
            end else begin
              mc_wr_d   = 1'b0;
              mc_addr_d = bus.i_addr;
              mc_len_d  = 3'b010;
              mc_data_d = '0;
            end
          end
        end
        BUSY: begin
          first_d = 1'b0;
          // The controller cannot be aborted, so a flushed fetch runs on and is only muted.
          if (flush && !owner_is_d_q) begin
            drop_d = 1'b1;
          end
          if (complete) begin
            state_d    = IDLE;
            mc_valid_d = 1'b0;
            mc_wr_d    = 1'b0;
            mc_len_d   = 3'b000;
            d_ready_c  = owner_is_d_q;
            i_ready_c  = !owner_is_d_q && !drop_q && !flush;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and controller-request registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      owner_is_d_q <= 1'b0;
      first_q      <= 1'b0;
      drop_q       <= 1'b0;
      last_d_q     <= 1'b0;
      mc_valid_q   <= 1'b0;
      mc_wr_q      <= 1'b0;
      mc_addr_q    <= '0;
      mc_len_q     <= 3'b000;
      mc_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_is_d_q <= owner_is_d_d;
      first_q      <= first_d;
      drop_q       <= drop_d;
      last_d_q     <= last_d_d;
      mc_valid_q   <= mc_valid_d;
      mc_wr_q      <= mc_wr_d;
      mc_addr_q    <= mc_addr_d;
      mc_len_q     <= mc_len_d;
      mc_data_q    <= mc_data_d;
    end
  end

  assign bus.mc_valid = mc_valid_q;
  assign bus.mc_wr    = mc_wr_q;
  assign bus.mc_addr  = mc_addr_q;
  assign bus.mc_len   = mc_len_q;
  assign bus.mc_data  = mc_data_q;
  assign bus.i_ready  = i_ready_c;
  assign bus.d_ready  = d_ready_c;
  // Result is forwarded only alongside its ready pulse, so it reads 0 otherwise.
  assign bus.i_data   = i_ready_c ? bus.mc_res : 32'd0;
  assign bus.d_rdata  = d_ready_c ? bus.mc_res : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
  localparam int ADDR_W = 32;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic flush;

  mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .flush  (flush),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int vectors = 0;
  int miscompares = 0;

  // controller model
  int          ctl_cnt, ctl_lat;
  int          fixed_lat = -1;
  bit          res_fixed = 1'b0;
  logic [31:0] res_val = 32'd0;
  bit          prev_mcv = 1'b0;
  logic [31:0] obs[$];

  // captured outputs of the last stepped cycle
  bit          cap_i, cap_d;
  logic [31:0] cap_idata, cap_drdata;

  // reference model of the arbiter
  bit          m_busy, m_owner_d, m_drop, m_last_d;
  int          m_cnt;
  logic        m_wr;
  logic [31:0] m_addr, m_data, m_res;
  logic [2:0]  m_len;

  typedef struct {
    bit          port_d;
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  len;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] res;
    logic        exp_wr;
    logic [2:0]  exp_len;
    logic [31:0] exp_mcdata;
    int          exp_cycles;
  } vec_t;

  vec_t vecs[5];

  function automatic logic [31:0] resp(input logic [31:0] a, input logic w);
    return {a[15:0], a[31:16]} ^ 32'h5A5AC3C3 ^ {31'd0, w};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner_d = 0; m_drop = 0; m_last_d = 0; m_cnt = 0;
    m_wr = 0; m_addr = '0; m_data = '0; m_res = '0; m_len = '0;
    prev_mcv = 0;
  endtask

  task automatic check_cycle();
    bit comp, exp_i, exp_d, ic, dc, gd;
    chk("mc_valid", bus.mc_valid, m_busy);
    chk("mc_addr", bus.mc_addr, m_addr);
    chk("mc_data", bus.mc_data, m_data);
    chk("mc_wr", bus.mc_wr, m_busy ? m_wr : 1'b0);
    chk("mc_len", bus.mc_len, m_busy ? m_len : 3'b000);
    comp  = !rst_in && m_busy && (m_cnt >= 1) && rdy_in && bus.mc_ready;
    exp_i = comp && !m_owner_d && !m_drop && !flush;
    exp_d = comp && m_owner_d;
    chk("i_ready", bus.i_ready, exp_i);
    chk("d_ready", bus.d_ready, exp_d);
    if (exp_i) chk("i_data", bus.i_data, m_res);
    if (exp_d) chk("d_rdata", bus.d_rdata, m_res);
    if (!rst_in && rdy_in) begin
      if (m_busy) begin
        if (flush && !m_owner_d) m_drop = 1;
        m_cnt++;
        if (comp) m_busy = 0;
      end else begin
        ic = bus.i_valid && !flush;
        dc = bus.d_valid;
        if (ic || dc) begin
          gd        = dc && !(ic && m_last_d);
          m_busy    = 1; m_owner_d = gd; m_last_d = gd; m_drop = 0; m_cnt = 0;
          m_wr      = gd ? bus.d_wr : 1'b0;
          m_addr    = gd ? bus.d_addr : bus.i_addr;
          m_len     = gd ? bus.d_len : 3'b010;
          m_data    = gd ? bus.d_wdata : 32'd0;
          m_res     = res_fixed ? res_val : resp(m_addr, m_wr);
        end
      end
    end
  endtask

  // one clock cycle: called and returns at posedge+1
  task automatic step();
    if (bus.mc_valid) begin
      if (!prev_mcv) begin
        ctl_cnt = 0;
        ctl_lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 5));
        obs.push_back(bus.mc_addr);
      end else begin
        ctl_cnt++;
      end
      bus.mc_ready = (ctl_cnt >= ctl_lat);
      bus.mc_res   = res_fixed ? res_val : resp(bus.mc_addr, bus.mc_wr);
    end else begin
      bus.mc_ready = 1'($urandom_range(0, 1));
      bus.mc_res   = $urandom;
    end
    @(negedge clk_in);
    check_cycle();
    cap_i = bus.i_ready; cap_d = bus.d_ready;
    cap_idata = bus.i_data; cap_drdata = bus.d_rdata;
    prev_mcv = bus.mc_valid;
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1; flush = 0; rdy_in = 1;
    bus.i_valid = 0; bus.d_valid = 0;
    model_reset();
    step();
    step();
    rst_in = 0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int seen = -1;
    logic [31:0] got = '0;
    fixed_lat = v.lat; res_fixed = 1; res_val = v.res;
    if (v.port_d) begin
      bus.d_valid = 1; bus.d_wr = v.wr; bus.d_addr = v.addr; bus.d_len = v.len; bus.d_wdata = v.wdata;
    end else begin
      bus.i_valid = 1; bus.i_addr = v.addr;
    end
    for (int c = 0; c < 24 && seen < 0; c++) begin
      if (c == 1) begin
        chk($sformatf("v%0d_mc_valid", idx), bus.mc_valid, 1);
        chk($sformatf("v%0d_mc_wr", idx), bus.mc_wr, v.exp_wr);
        chk($sformatf("v%0d_mc_len", idx), bus.mc_len, v.exp_len);
        chk($sformatf("v%0d_mc_data", idx), bus.mc_data, v.exp_mcdata);
        chk($sformatf("v%0d_mc_addr", idx), bus.mc_addr, v.addr);
      end
      step();
      if (v.port_d ? cap_d : cap_i) begin
        seen = c;
        got  = v.port_d ? cap_drdata : cap_idata;
      end
    end
    bus.i_valid = 0; bus.d_valid = 0;
    chk($sformatf("v%0d_ready_cycle", idx), seen, v.exp_cycles);
    chk($sformatf("v%0d_result", idx), got, v.res);
    chk($sformatf("v%0d_idle_after", idx), bus.mc_valid, 0);
    step();
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen, nready;
    bit ri_pend, rd_pend, last_flush;
    logic [31:0] ri_addr, rd_addr;
    logic rd_wr;

    vecs[0] = '{0, 0, 32'h0000_1000, 3'b010, 32'h0, 4, 32'hDEADBEEF, 0, 3'b010, 32'h0, 5};
    vecs[1] = '{1, 1, 32'h0003_0000, 3'b000, 32'h41, 10, 32'h0, 1, 3'b000, 32'h41, 11};
    vecs[2] = '{1, 0, 32'h0000_2002, 3'b101, 32'h12345678, 1, 32'hFFFF8001, 0, 3'b101, 32'h12345678, 2};
    vecs[3] = '{1, 0, 32'h0000_0040, 3'b010, 32'h0, 0, 32'h0BADF00D, 0, 3'b010, 32'h0, 2};
    vecs[4] = '{0, 0, 32'hFFFF_FFFC, 3'b010, 32'h0, 2, 32'h13579BDF, 0, 3'b010, 32'h0, 3};

    rst_in = 1; rdy_in = 1; flush = 0;
    bus.i_valid = 0; bus.i_addr = '0;
    bus.d_valid = 0; bus.d_wr = 0; bus.d_addr = '0; bus.d_len = '0; bus.d_wdata = '0;
    bus.mc_ready = 0; bus.mc_res = '0;
    model_reset();
    @(posedge clk_in); #1;
    chk("reset_mc_valid", bus.mc_valid, 0);
    chk("reset_mc_addr", bus.mc_addr, 0);
    chk("reset_mc_len", bus.mc_len, 0);
    do_reset();

    // table-driven single transactions
    foreach (vecs[k]) run_vec(k, vecs[k]);

    // both ports saturated from reset: D, I, D, I
    do_reset();
    fixed_lat = 1; res_fixed = 0;
    bus.i_valid = 1; bus.i_addr = 32'h100;
    bus.d_valid = 1; bus.d_wr = 0; bus.d_addr = 32'h200; bus.d_len = 3'b010; bus.d_wdata = 0;
    obs.delete();
    for (int c = 0; c < 40 && obs.size() < 4; c++) step();
    bus.i_valid = 0; bus.d_valid = 0;
    chk("order_count", obs.size(), 4);
    if (obs.size() >= 4) begin
      chk("order_0", obs[0], 32'h200);
      chk("order_1", obs[1], 32'h100);
      chk("order_2", obs[2], 32'h200);
      chk("order_3", obs[3], 32'h100);
    end
    for (int c = 0; c < 6; c++) step();

    // flush in the second BUSY cycle of a fetch, then refetch 0x2000
    do_reset();
    fixed_lat = 3; res_fixed = 0; obs.delete(); nready = 0; seen = 0;
    bus.i_valid = 1; bus.i_addr = 32'h1000;
    step(); step();
    flush = 1; bus.i_addr = 32'h2000;
    step();
    flush = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (cap_i) begin nready++; chk("flush_i_data", cap_idata, resp(32'h2000, 0)); bus.i_valid = 0; end
    end
    chk("flush_ready_count", nready, 1);
    chk("flush_grants", obs.size(), 2);
    if (obs.size() >= 2) chk("flush_regrant_addr", obs[1], 32'h2000);

    // rdy_in low for 3 cycles across the mc_ready cycle
    do_reset();
    fixed_lat = 2; seen = -1; nready = 0;
    bus.d_valid = 1; bus.d_wr = 0; bus.d_addr = 32'h500; bus.d_len = 3'b010; bus.d_wdata = 0;
    for (int c = 0; c < 12; c++) begin
      rdy_in = !(c >= 2 && c <= 4);
      step();
      if (cap_d) begin if (seen < 0) seen = c; nready++; bus.d_valid = 0; end
    end
    rdy_in = 1;
    chk("rdy_ready_cycle", seen, 5);
    chk("rdy_ready_count", nready, 1);

    // asynchronous reset in the middle of a word fetch
    do_reset();
    fixed_lat = 5;
    bus.i_valid = 1; bus.i_addr = 32'h3000;
    step(); step(); step();
    #2 rst_in = 1;
    #1;
    chk("arst_mc_valid", bus.mc_valid, 0);
    chk("arst_mc_addr", bus.mc_addr, 0);
    chk("arst_mc_data", bus.mc_data, 0);
    chk("arst_i_ready", bus.i_ready, 0);
    chk("arst_d_ready", bus.d_ready, 0);
    chk("arst_i_data", bus.i_data, 0);
    bus.i_valid = 0;
    model_reset();
    step(); step();
    rst_in = 0;
    fixed_lat = 1; nready = 0;
    bus.i_valid = 1; bus.i_addr = 32'h3004;
    for (int c = 0; c < 10; c++) begin
      step();
      if (cap_i) begin nready++; chk("arst_after_data", cap_idata, resp(32'h3004, 0)); bus.i_valid = 0; end
    end
    chk("arst_after_count", nready, 1);

    // randomized traffic against the reference model and requester scoreboards
    do_reset();
    fixed_lat = -1; res_fixed = 0;
    ri_pend = 0; rd_pend = 0; last_flush = 0;
    ri_addr = '0; rd_addr = '0; rd_wr = 0;
    cap_i = 0; cap_d = 0;
    for (int n = 0; n < 3000; n++) begin
      if (cap_i) begin chk("rand_i_data", cap_idata, resp(ri_addr, 0)); ri_pend = 0; end
      if (cap_d) begin chk("rand_d_rdata", cap_drdata, resp(rd_addr, rd_wr)); rd_pend = 0; end
      if (last_flush) ri_pend = 0;
      rdy_in = ($urandom_range(0, 9) != 0);
      flush  = rdy_in && ($urandom_range(0, 19) == 0);
      if (!ri_pend && $urandom_range(0, 1) == 1) begin
        ri_pend = 1; ri_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!rd_pend && $urandom_range(0, 1) == 1) begin
        rd_pend = 1; rd_addr = $urandom; rd_wr = 1'($urandom_range(0, 1));
        bus.d_len = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
        bus.d_wdata = $urandom;
      end
      bus.i_valid = ri_pend; bus.i_addr = ri_addr;
      bus.d_valid = rd_pend; bus.d_addr = rd_addr; bus.d_wr = rd_wr;
      step();
      last_flush = flush;
    end
    bus.i_valid = 0; bus.d_valid = 0; flush = 0; rdy_in = 1;
    for (int c = 0; c < 12; c++) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
